// File: rtl/wave_select_mux.sv
// Glitch-free waveform channel selector: switches channels only at a period
// boundary (or after a timeout) and inserts a mid-scale blank at each switch.
module wave_select_mux #(
  parameter int N            = 7,
  parameter int W            = 8,
  parameter int SELW         = 3,
  parameter int BLANK_CYCLES = 4,
  parameter int TIMEOUT      = 1023
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SELW-1:0] sel,
  input  logic [N*W-1:0]  din,
  input  logic            wrap_i,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] cur_sel,
  output logic            busy,
  output logic            sel_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);
  localparam logic [BW-1:0]   B_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [W-1:0]    MID    = W'(1) << (W - 1);
  localparam logic [SELW:0]   N_LIM  = (SELW + 1)'(N);

  typedef enum logic [1:0] {IDLE, PENDING, BLANK} state_t;

  state_t          state, state_nx;
  logic [SELW-1:0] s1, s2, pend_sel, pend_nx, cur_nx;
  logic [TW-1:0]   tcnt, tcnt_nx;
  logic [BW-1:0]   bcnt, bcnt_nx;
  logic [W-1:0]    dout_nx, cur_data, pend_data;
  logic            s2_ok;

  // N need not be a power of two, so widen by one bit before comparing.
  assign s2_ok = ({1'b0, s2} < N_LIM);

  always_comb begin
    cur_data  = '0;
    pend_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (cur_sel == SELW'(k))  cur_data  = din[k*W +: W];
      if (pend_sel == SELW'(k)) pend_data = din[k*W +: W];
    end
  end

  always_comb begin
    state_nx = state;
    pend_nx  = pend_sel;
    cur_nx   = cur_sel;
    tcnt_nx  = tcnt;
    bcnt_nx  = bcnt;
    dout_nx  = cur_data;
    case (state)
      IDLE: begin
        if (s2_ok && s2 != cur_sel) begin
          pend_nx  = s2;
          tcnt_nx  = '0;
          state_nx = PENDING;
        end
      end
      PENDING: begin
        tcnt_nx = tcnt + 1'b1;
        if (wrap_i || tcnt == T_LAST) begin
          cur_nx  = pend_sel;
          bcnt_nx = '0;
          if (BLANK_CYCLES > 0) begin
            dout_nx  = MID;
            state_nx = BLANK;
          end else begin
            dout_nx  = pend_data;
            state_nx = IDLE;
          end
        end else if (s2 == cur_sel) begin
          state_nx = IDLE;
        end else if (s2_ok && s2 != pend_sel) begin
          pend_nx = s2;
          tcnt_nx = '0;
        end
      end
      BLANK: begin
        dout_nx = MID;
        bcnt_nx = bcnt + 1'b1;
        if (bcnt == B_LAST) begin
          dout_nx  = cur_data;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      state    <= IDLE;
      pend_sel <= '0;
      cur_sel  <= '0;
      tcnt     <= '0;
      bcnt     <= '0;
      dout     <= '0;
      busy     <= 1'b0;
      sel_err  <= 1'b0;
    end else begin
      s1       <= sel;
      s2       <= s1;
      state    <= state_nx;
      pend_sel <= pend_nx;
      cur_sel  <= cur_nx;
      tcnt     <= tcnt_nx;
      bcnt     <= bcnt_nx;
      dout     <= dout_nx;
      busy     <= (state_nx != IDLE);
      sel_err  <= !s2_ok;
    end
  end

endmodule

// File: tb/tb_wave_select_mux.sv
// Bench for wave_select_mux: directed scenarios plus a randomized run, all
// checked against an event-level reference model of the selector.
module tb_wave_select_mux;

  localparam int N    = 7;
  localparam int W    = 8;
  localparam int SELW = 3;
  localparam int BC   = 4;
  localparam int TO   = 16;
  localparam logic [W-1:0] MID = 8'h80;

  logic            clk = 1'b0;
  logic            rst;
  logic [SELW-1:0] sel;
  logic [N*W-1:0]  din;
  logic            wrap_i;
  logic [W-1:0]    dout;
  logic [SELW-1:0] cur_sel;
  logic            busy;
  logic            sel_err;

  wave_select_mux #(
    .N(N), .W(W), .SELW(SELW), .BLANK_CYCLES(BC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .din(din), .wrap_i(wrap_i),
    .dout(dout), .cur_sel(cur_sel), .busy(busy), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Channels pinned to known values during directed steps.
  bit          fix_en  [N];
  logic [W-1:0] fix_val [N];

  // Reference model: synchroniser history, current channel, pending request
  // with its age, and the number of blanking edges still to go.
  int          m_s1, m_s2, m_cur, m_pend, m_age, m_blank_left;
  bit          m_pending;
  logic [W-1:0] m_dout;
  bit          m_busy, m_err;

  function automatic logic [W-1:0] chan(input int k);
    return din[k*W +: W];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_s1 = 0; m_s2 = 0; m_cur = 0; m_pend = 0; m_age = 0;
    m_blank_left = 0; m_pending = 0; m_dout = '0; m_busy = 0; m_err = 0;
  endtask

  task automatic model_step;
    bit valid;
    valid = (m_s2 < N);
    if (m_blank_left > 0) begin
      m_blank_left--;
      m_dout = (m_blank_left == 0) ? chan(m_cur) : MID;
    end else if (m_pending) begin
      m_age++;
      m_dout = chan(m_cur);
      if (wrap_i || m_age == TO) begin
        m_pending = 0;
        m_dout    = MID;
        m_blank_left = BC;
        m_cur     = m_pend;
      end else if (m_s2 == m_cur) begin
        m_pending = 0;
      end else if (valid && m_s2 != m_pend) begin
        m_pend = m_s2;
        m_age  = 0;
      end
    end else begin
      m_dout = chan(m_cur);
      if (valid && m_s2 != m_cur) begin
        m_pending = 1;
        m_pend    = m_s2;
        m_age     = 0;
      end
    end
    m_busy = m_pending || (m_blank_left > 0);
    m_err  = !valid;
    m_s2   = m_s1;
    m_s1   = int'(sel);
  endtask

  task automatic new_din;
    for (int k = 0; k < N; k++)
      din[k*W +: W] = fix_en[k] ? fix_val[k] : W'($urandom);
  endtask

  task automatic tick;
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check("dout", dout, m_dout);
    check("cur_sel", cur_sel, m_cur);
    check("busy", busy, m_busy);
    check("sel_err", sel_err, m_err);
    new_din();
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin fix_en[k] = 0; fix_val[k] = '0; end
    fix_en[0] = 1; fix_val[0] = 8'h5A;
    fix_en[2] = 1; fix_val[2] = 8'h2D;
    fix_en[3] = 1; fix_val[3] = 8'hC3;
    sel = '0; wrap_i = 1'b0; rst = 1'b0;
    new_din();
    #1 rst = 1'b1;
    model_reset();
    #1;
    check("rst_dout", dout, 8'h00);
    check("rst_cur", cur_sel, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", sel_err, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst_dout", dout, 8'h5A);

    // Boundary switch 0 -> 3, wrap on the 7th edge after the change.
    sel = 3'd3;
    for (int i = 0; i <= 10; i++) begin
      wrap_i = (i == 6);
      tick();
      if (i == 1) check("bnd_busy_early", busy, 1'b0);
      if (i >= 2 && i <= 9) check("bnd_busy", busy, 1'b1);
      if (i == 5) check("bnd_hold", dout, 8'h5A);
      if (i >= 6 && i <= 9) check("bnd_mid", dout, MID);
      if (i == 10) begin
        check("bnd_dout", dout, 8'hC3);
        check("bnd_cur", cur_sel, 3'd3);
        check("bnd_busy_end", busy, 1'b0);
      end
    end
    wrap_i = 1'b0;

    // Timeout switch 3 -> 2 with no wrap: PENDING at edge 2, commit at 18.
    sel = 3'd2;
    for (int i = 0; i <= 22; i++) begin
      tick();
      if (i == 17) begin
        check("to_early_cur", cur_sel, 3'd3);
        check("to_early_dout", dout, 8'hC3);
      end
      if (i >= 18 && i <= 21) check("to_mid", dout, MID);
      if (i == 22) begin
        check("to_dout", dout, 8'h2D);
        check("to_cur", cur_sel, 3'd2);
        check("to_busy", busy, 1'b0);
      end
    end

    // Invalid select is flagged and never requested.
    sel = 3'd7;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i >= 2) begin
        check("inv_err", sel_err, 1'b1);
        check("inv_busy", busy, 1'b0);
        check("inv_dout", dout, 8'h2D);
      end
    end

    // Cancel: 2 -> 4 -> back to 2 before any wrap.
    sel = 3'd4;
    repeat (4) tick();
    check("cxl_pending", busy, 1'b1);
    sel = 3'd2;
    repeat (3) tick();
    check("cxl_busy", busy, 1'b0);
    check("cxl_cur", cur_sel, 3'd2);
    check("cxl_dout", dout, 8'h2D);

    // Retarget: 2 -> 4 -> 5, then wrap.
    sel = 3'd4;
    repeat (4) tick();
    sel = 3'd5;
    repeat (4) tick();
    wrap_i = 1'b1;
    tick();
    wrap_i = 1'b0;
    check("rt_cur", cur_sel, 3'd5);
    repeat (4) tick();
    check("rt_busy", busy, 1'b0);

    // Reset in the middle of blanking.
    sel = 3'd1;
    repeat (4) tick();
    wrap_i = 1'b1;
    tick();
    wrap_i = 1'b0;
    tick();
    check("rb_in_blank", dout, MID);
    sel = 3'd0;
    rst = 1'b1;
    model_reset();
    #1;
    check("rb_dout", dout, 8'h00);
    check("rb_cur", cur_sel, 3'd0);
    check("rb_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("rb_after", dout, 8'h5A);
    repeat (3) tick();

    // Randomized traffic including invalid selects and occasional resets.
    for (int k = 0; k < N; k++) fix_en[k] = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) sel = SELW'($urandom_range(0, 7));
      wrap_i = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
      end
      tick();
    end
    wrap_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wave_select_mux.md
# wave_select_mux

Parametrised, glitch-free waveform source selector for the function generator. It picks one of N W-bit waveform channels, named by a front-panel select switch, and drives it to the DAC path through an output register. A channel change commits only at a waveform period boundary (or after a timeout). Each commit inserts a short mid-scale blanking interval, so the DAC never sees a discontinuous jump between waveforms.

## Interface
- N, 7: number of input channels (2..16).
- W, 8: sample width in bits.
- SELW, 3: select width; must satisfy 2^SELW >= N.
- BLANK_CYCLES, 4: cycles of mid-scale output inserted at each commit (0 disables blanking).
- TIMEOUT, 1023: maximum cycles a request waits for a period boundary (>= 1).
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- sel  input  SELW  requested channel, asynchronous to clk (switch input).
- din  input  N*W  flattened channels; channel k occupies bits [k*W +: W].
- wrap_i  input  1  one-cycle strobe at the period boundary of the currently selected waveform.
- dout  output  W  registered selected sample.
- cur_sel  output  SELW  channel currently routed to dout.
- busy  output  1  high while a switch is pending or blanking.
- sel_err  output  1  high while the synchronised sel is >= N.

## Operation
- sel passes through a 2-flop synchroniser (s1 -> s2); all decisions use s2. Both flops reset to 0.
- MID = 2^(W-1).
- Reset values: dout=0, cur_sel=0, busy=0, sel_err=0, state=IDLE, pend_sel=0, counters=0.
- sel_err is registered each cycle as (s2 >= N). An invalid s2 never creates, modifies, or cancels a request.
- Registered busy = (next state != IDLE).
- IDLE:
  - dout <= din[cur_sel].
  - If s2 is valid and s2 != cur_sel: pend_sel <= s2, tcnt <= 0, go to PENDING.
  - wrap_i is ignored.
- PENDING:
  - dout <= din[cur_sel]; tcnt increments.
  - Commit when wrap_i=1 or tcnt == TIMEOUT-1. On commit: cur_sel <= pend_sel, bcnt <= 0. If BLANK_CYCLES > 0, dout <= MID and go to BLANK; otherwise dout <= din[pend_sel] and go to IDLE.
  - Otherwise, if s2 == cur_sel: cancel and return to IDLE (no blanking).
  - Otherwise, if s2 is valid and s2 != pend_sel: pend_sel <= s2, tcnt <= 0.
  - Commit has priority over a simultaneous sel change. The new value is re-evaluated from IDLE afterwards.
- BLANK:
  - dout <= MID; bcnt increments.
  - When bcnt == BLANK_CYCLES-1: dout <= din[cur_sel] and go to IDLE.
  - s2 and wrap_i are ignored.
- Counter widths: tcnt uses clog2(TIMEOUT+1) bits; bcnt uses clog2(BLANK_CYCLES+1) bits. Neither may wrap.

## Timing
- din to dout: 1 cycle (registered) in IDLE/PENDING.
- sel change to PENDING:
  - sel stable before edge t gives s2 valid after edge t+1.
  - State = PENDING and busy=1 after edge t+2.
- Commit at edge e (wrap_i sampled high at e, or the TIMEOUT-th PENDING edge):
  - dout = MID after edges e .. e+BLANK_CYCLES-1.
  - dout = new channel and busy=0 after edge e+BLANK_CYCLES.
  - cur_sel updates after edge e.
- Timeout: entered PENDING at edge p with no wrap_i gives commit at edge p+TIMEOUT.
- wrap_i on the same edge that enters PENDING does not commit, because the state was IDLE at that edge.
- rst mid-operation: all outputs and state return to reset values immediately (asynchronous). The first post-reset sample is din[0] after the first edge.

## Test plan
- Reset:
  - Stimulus: rst=1 with din channel 0 = 8'h5A.
  - Required: dout=0, cur_sel=0, busy=0, sel_err=0. One edge after release, dout=8'h5A.
- Boundary switch:
  - Stimulus: sel 0->3 at edge t; wrap_i pulsed at edge t+6; ch3 = 8'hC3.
  - Required: busy=1 from t+2; dout=8'h80 after edges t+6..t+9; dout=8'hC3, cur_sel=3, busy=0 after edge t+10.
- Timeout:
  - Stimulus: TIMEOUT=16, sel 0->2, no wrap_i.
  - Required: commit exactly 16 edges after entering PENDING, then 4 MID cycles, then ch2.
- Invalid select:
  - Stimulus: N=7, sel=7.
  - Required: sel_err=1 two edges later; state stays IDLE; dout tracks ch0; busy=0.
- Cancel and retarget:
  - Stimulus: sel 0->4, then 4->0 before wrap_i.
  - Required: return to IDLE with no blanking and cur_sel=0.
  - Stimulus: sel 0->4->5, then wrap_i.
  - Required: cur_sel=5.
- Reset during BLANK:
  - Stimulus: assert rst on the second blanking cycle.
  - Required: dout=0, cur_sel=0, busy=0 immediately. After release, normal IDLE operation on ch0.
